// File: rtl/lfsr_modulator.sv
// lfsr_modulator: fast-domain source stage of the modulated sample stream.
// A free-running divider raises a one-cycle strobe every DIV clocks. Each strobe
// steps a 5-bit Fibonacci LFSR (x^5+x^3+1). The LFSR's bit 0 keys one of four
// modulation schemes over two DDS waveforms. The result is registered into mod_out,
// which feeds a clock-domain crossing and must therefore come straight from a flop.
//
// Ports:
//   fast_clk   in   1  sole clock, rising edge
//   reset      in   1  synchronous, active-high
//   sig_a      in   N  DDS waveform A (two's complement): carrier / FSK low tone
//   sig_b      in   N  DDS waveform B (two's complement): FSK high tone
//   mod_sel    in   2  00=ASK, 01=FSK, 10=BPSK, 11=raw LFSR
//   mod_out    out  N  registered modulated sample
//   lfsr_state out  5  current LFSR register
//   lfsr_bit   out  1  lfsr_state[0], the modulating bit
//   lfsr_tick  out  1  strobe, high in the cycle the LFSR steps
module lfsr_modulator #(
  parameter int unsigned N         = 12,
  parameter int unsigned DIV       = 50000000,
  parameter logic [4:0]  LFSR_SEED = 5'b00001
) (
  input  logic         fast_clk,
  input  logic         reset,
  input  logic [N-1:0] sig_a,
  input  logic [N-1:0] sig_b,
  input  logic [1:0]   mod_sel,
  output logic [N-1:0] mod_out,
  output logic [4:0]   lfsr_state,
  output logic         lfsr_bit,
  output logic         lfsr_tick
);

  localparam int unsigned CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [N-1:0]  PosMax = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  NegMin = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  OneN   = {{(N-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [4:0]    r_lfsr;
  logic [N-1:0]  r_mod;

  logic          w_fb;
  logic          w_bit;
  logic [N-1:0]  w_neg_a;
  logic [N-1:0]  w_mod;

  assign w_bit = r_lfsr[0];
  assign w_fb  = r_lfsr[0] ^ r_lfsr[2];

  // Modulation is computed from the current bit, so a new LFSR bit shows up in
  // mod_out one cycle after lfsr_state changes.
  always_comb begin
    // Saturating negate: the most negative code has no positive twin.
    w_neg_a = (sig_a == NegMin) ? PosMax : (~sig_a + OneN);
    w_mod   = '0;
    case (mod_sel)
      2'b00:   w_mod = w_bit ? sig_a : '0;
      2'b01:   w_mod = w_bit ? sig_b : sig_a;
      2'b10:   w_mod = w_bit ? sig_a : w_neg_a;
      default: w_mod = w_bit ? PosMax : NegMin;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_lfsr <= LFSR_SEED;
      r_mod  <= '0;
    end else begin
      if (r_cnt == CntMax) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CntOne;
        r_tick <= 1'b0;
      end

      // All-zero is a lock-up state for this LFSR; recover to the seed.
      if (r_lfsr == 5'b00000) begin
        r_lfsr <= LFSR_SEED;
      end else if (r_tick) begin
        r_lfsr <= {w_fb, r_lfsr[4:1]};
      end

      r_mod <= w_mod;
    end
  end

  assign mod_out    = r_mod;
  assign lfsr_state = r_lfsr;
  assign lfsr_bit   = w_bit;
  assign lfsr_tick  = r_tick;

endmodule
